// File: rtl/onehot_pkg.sv
// Shared types for the one-hot decoder: code width, derived output width,
// the stored word format and the decode function.
package onehot_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 2 ** CODE_W;

  typedef struct packed {
    logic              zero;
    logic [CODE_W-1:0] code;
  } dec_word_t;

  function automatic logic [OUT_W-1:0] onehot_of(input dec_word_t w);
    logic [OUT_W-1:0] r;
    r = '0;
    if (!w.zero) r[w.code] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/onehot_skid.sv
// Generic two-entry valid/ready skid register: a main (output) entry plus one
// skid entry. in_ready_o is registered and equals the inverse of skid_valid_q.
module onehot_skid
  import onehot_pkg::*;
#(
  parameter type word_t = dec_word_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid_i,
  output logic  in_ready_o,
  input  word_t in_word_i,
  output logic  out_valid_o,
  input  logic  out_ready_i,
  output word_t out_word_o,
  output logic  deliver_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never waits for ready, and ready is a pure register here.
  logic  main_valid_q, main_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  ready_q;
  word_t main_q, main_d;
  word_t skid_q, skid_d;
  logic  accept;
  logic  deliver;

  assign accept  = in_valid_i && ready_q;
  assign deliver = main_valid_q && out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (deliver) begin
      if (skid_valid_q) begin
        // ready_q is low while skid is full, so no accept can coincide here
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = in_word_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_d       = in_word_i;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_word_i;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = main_valid_q;
  assign out_word_o  = main_q;
  assign deliver_o   = deliver;

endmodule

// File: rtl/onehot_decoder.sv
// Registered 3-to-8 one-hot decoder behind a two-entry skid buffer.
// Optional delivery counter enabled by ONEHOT_DEC_COUNT_EN.
module onehot_decoder
  import onehot_pkg::*;
#(
  parameter int CODE_W = onehot_pkg::CODE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CODE_W-1:0]    in_code,
  input  logic                 in_zero,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef ONEHOT_DEC_COUNT_EN
  output logic [2**CODE_W-1:0] out,
  output logic [15:0]          dec_count
`else
  output logic [2**CODE_W-1:0] out
`endif
);

  localparam int OUT_W = 2 ** CODE_W;

  dec_word_t in_word;
  dec_word_t main_word;
  logic      deliver;

  assign in_word.zero = in_zero;
  assign in_word.code = in_code;

  onehot_skid #(.word_t(dec_word_t)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_word_i   (in_word),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_word_o  (main_word),
    .deliver_o   (deliver)
  );

  // Decoding at the storage output keeps entries narrow; gating on valid
  // keeps out at zero whenever main is empty.
  assign out = out_valid ? OUT_W'(onehot_of(main_word)) : '0;

`ifdef ONEHOT_DEC_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (deliver && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 16'd0;
    else        count_q <= count_d;
  end

  assign dec_count = count_q;
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
`endif

endmodule

// File: tb/tb_onehot_decoder.sv
// Directed and randomized-handshake bench for onehot_decoder with an
// expected-word queue; counter checks run when ONEHOT_DEC_COUNT_EN is defined.
module tb_onehot_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic       in_zero;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
`ifdef ONEHOT_DEC_COUNT_EN
  logic [15:0] dec_count;
`endif

  int vectors;
  int miscompares;
  logic [7:0] exp_q[$];
  logic       prev_stall;
  logic [7:0] prev_out;
  logic       last_acc;
  int         accepted;
  int         budget;
  logic [7:0] tbl [8];

  onehot_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ONEHOT_DEC_COUNT_EN
    .out       (out),
    .dec_count (dec_count)
`else
    .out       (out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven: scores the coming edge,
  // then advances to the next negedge.
  task automatic tick();
    logic [7:0] e;
    if (prev_stall) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_out", {24'd0, out}, {24'd0, prev_out});
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = out;
    last_acc   = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", {31'd0, out_valid}, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("order", {24'd0, out}, {24'd0, e});
      end
    end
    if (last_acc) exp_q.push_back(in_zero ? 8'h00 : (8'h01 << in_code));
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic z);
    in_valid = v;
    in_code  = c;
    in_zero  = z;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    prev_stall  = 1'b0;
    prev_out    = 8'h00;
    last_acc    = 1'b0;
    tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 1'b0);

    // Reset state
    @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", {24'd0, out}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
`ifdef ONEHOT_DEC_COUNT_EN
    chk("rst_count", {16'd0, dec_count}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Codes 0..7 back to back with the consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 1'b0);
      chk("stream_ready", {31'd0, in_ready}, 32'd1);
      tick();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_out", {24'd0, out}, {24'd0, tbl[i]});
    end
    drive(1'b0, 3'd0, 1'b0);
    tick();
    chk("stream_empty", {31'd0, out_valid}, 32'd0);

    // Explicit zero request ignores the code
    drive(1'b1, 3'd5, 1'b1);
    tick();
    chk("zero_valid", {31'd0, out_valid}, 32'd1);
    chk("zero_out", {24'd0, out}, 32'h00);
    drive(1'b1, 3'd3, 1'b0);
    tick();
    chk("after_zero_valid", {31'd0, out_valid}, 32'd1);
    chk("after_zero_out", {24'd0, out}, 32'h08);
    drive(1'b0, 3'd0, 1'b0);
    tick();

    // Back-pressure: 1 to main, 2 to skid, 6 waits
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 1'b0);
    tick();
    chk("bp_ready1", {31'd0, in_ready}, 32'd1);
    chk("bp_out1", {24'd0, out}, 32'h02);
    drive(1'b1, 3'd2, 1'b0);
    tick();
    chk("bp_ready_drop", {31'd0, in_ready}, 32'd0);
    chk("bp_out2", {24'd0, out}, 32'h02);
    drive(1'b1, 3'd6, 1'b0);
    tick();
    chk("bp_wait_accept", {31'd0, last_acc}, 32'd0);
    chk("bp_hold_out", {24'd0, out}, 32'h02);
    out_ready = 1'b1;
    tick();
    chk("bp_drain_out", {24'd0, out}, 32'h04);
    chk("bp_ready_rise", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_last_out", {24'd0, out}, 32'h40);
    drive(1'b0, 3'd0, 1'b0);
    tick();
    chk("bp_queue_empty", exp_q.size(), 32'd0);

    // Random codes under random back-pressure
    accepted = 0;
    budget   = 0;
    while (accepted < 1000 && budget < 20000) begin
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
      out_ready = $urandom_range(0, 1) == 1;
      tick();
      if (last_acc) accepted++;
      budget++;
    end
    chk("rand_accepted", accepted, 32'd1000);
    drive(1'b0, 3'd0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rand_drained", exp_q.size(), 32'd0);

    // Reset with both entries full
    out_ready = 1'b0;
    drive(1'b1, 3'd4, 1'b0);
    tick();
    drive(1'b1, 3'd5, 1'b0);
    tick();
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 3'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out", {24'd0, out}, 32'h00);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    drive(1'b1, 3'd7, 1'b0);
    tick();
    chk("post_rst_out", {24'd0, out}, 32'h80);
    drive(1'b0, 3'd0, 1'b0);
    tick();

`ifdef ONEHOT_DEC_COUNT_EN
    // Saturating delivery counter
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 70001; i++) begin
      drive(1'b1, 3'(i), 1'b0);
      tick();
    end
    chk("count_sat", {16'd0, dec_count}, 32'h0000FFFF);
    for (int i = 0; i < 3; i++) tick();
    chk("count_hold", {16'd0, dec_count}, 32'h0000FFFF);
    drive(1'b0, 3'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("count_rst", {16'd0, dec_count}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
